// File: rtl/result_packetizer_if.sv
// rtl/result_packetizer_if.sv - start/result/byte-stream bundle of the result packetizer
interface result_packetizer_if #(
    parameter int N_CLASSES = 10,
    parameter int IDX_W     = 4
) ();
    logic                   i_start;
    logic [N_CLASSES*8-1:0] i_logits_flat;
    logic                   o_busy;
    logic                   o_done;
    logic [IDX_W-1:0]       o_class_idx;
    logic                   o_class_valid;
    logic [7:0]             o_tx_data;
    logic                   o_tx_valid;
    logic                   i_tx_ready;

    modport master (
        output i_start, i_logits_flat, i_tx_ready,
        input  o_busy, o_done, o_class_idx, o_class_valid, o_tx_data, o_tx_valid
    );

    modport slave (
        input  i_start, i_logits_flat, i_tx_ready,
        output o_busy, o_done, o_class_idx, o_class_valid, o_tx_data, o_tx_valid
    );
endinterface

// File: rtl/result_packetizer.sv
// rtl/result_packetizer.sv - signed argmax over captured logits, then framed checksummed byte stream
module result_packetizer #(
    parameter int         N_CLASSES = 10,
    parameter logic [7:0] HEADER    = 8'hA5,
    parameter int         IDX_W     = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    result_packetizer_if.slave bus
);
    localparam int                FRAME_LEN    = N_CLASSES + 3;
    localparam int                K_W          = $clog2(FRAME_LEN);
    localparam logic [K_W-1:0]    K_LAST       = K_W'(FRAME_LEN - 1);
    localparam logic [K_W-1:0]    K_CLASS      = K_W'(N_CLASSES + 1);
    localparam logic [K_W-1:0]    K_LOGIT_LAST = K_W'(N_CLASSES);
    localparam logic [IDX_W-1:0]  I_LAST       = IDX_W'(N_CLASSES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARGMAX, S_SEND, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;

    logic [7:0]        r_logits [N_CLASSES];
    logic signed [7:0] r_best;
    logic [IDX_W-1:0]  r_best_idx;
    logic [IDX_W-1:0]  r_i;
    logic [IDX_W-1:0]  r_class_idx;
    logic              r_class_valid;
    logic [K_W-1:0]    r_k;
    logic [7:0]        r_csum;

    logic signed [7:0] w_cand;
    logic              w_cand_wins;
    logic [7:0]        w_frame_byte;
    logic              w_accept;
    logic              w_handshake;

    // Strict greater-than keeps the earliest index on ties.
    assign w_accept    = (r_state == S_IDLE) && bus.i_start;
    assign w_handshake = (r_state == S_SEND) && bus.i_tx_ready;
    assign w_cand      = $signed(r_logits[r_i]);
    assign w_cand_wins = w_cand > r_best;

    assign bus.o_class_idx   = r_class_idx;
    assign bus.o_class_valid = r_class_valid;

    // State register; reset aborts any frame in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and state-decoded handshake/status outputs.
    always_comb begin
        w_next         = r_state;
        bus.o_busy     = 1'b1;
        bus.o_done     = 1'b0;
        bus.o_tx_valid = 1'b0;
        bus.o_tx_data  = 8'h00;
        case (r_state)
            S_IDLE: begin
                bus.o_busy = 1'b0;
                if (bus.i_start) begin
                    w_next = S_ARGMAX;
                end
            end
            S_ARGMAX: begin
                if (r_i == I_LAST) begin
                    w_next = S_SEND;
                end
            end
            S_SEND: begin
                bus.o_tx_valid = 1'b1;
                bus.o_tx_data  = w_frame_byte;
                if (bus.i_tx_ready && (r_k == K_LAST)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                bus.o_done = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Frame byte selected by the byte counter: header, logits, class, checksum.
    always_comb begin
        w_frame_byte = r_csum;
        if (r_k == '0) begin
            w_frame_byte = HEADER;
        end else if (r_k <= K_LOGIT_LAST) begin
            w_frame_byte = r_logits[r_k - K_W'(1)];
        end else if (r_k == K_CLASS) begin
            w_frame_byte = 8'(r_class_idx);
        end
    end

    // Logit capture, sequential argmax, byte counter and running checksum.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int j = 0; j < N_CLASSES; j++) begin
                r_logits[j] <= 8'h00;
            end
            r_best        <= '0;
            r_best_idx    <= '0;
            r_i           <= '0;
            r_class_idx   <= '0;
            r_class_valid <= 1'b0;
            r_k           <= '0;
            r_csum        <= 8'h00;
        end else begin
            if (w_accept) begin
                for (int j = 0; j < N_CLASSES; j++) begin
                    r_logits[j] <= bus.i_logits_flat[j*8 +: 8];
                end
                r_best        <= $signed(bus.i_logits_flat[7:0]);
                r_best_idx    <= '0;
                r_i           <= IDX_W'(1);
                r_class_valid <= 1'b0;
            end
            if (r_state == S_ARGMAX) begin
                if (w_cand_wins) begin
                    r_best     <= w_cand;
                    r_best_idx <= r_i;
                end
                r_i <= r_i + IDX_W'(1);
                if (r_i == I_LAST) begin
                    r_class_idx   <= w_cand_wins ? r_i : r_best_idx;
                    r_class_valid <= 1'b1;
                    r_k           <= '0;
                    r_csum        <= 8'h00;
                end
            end
            if (w_handshake) begin
                r_k <= r_k + K_W'(1);
                if (r_k != K_LAST) begin
                    r_csum <= r_csum ^ w_frame_byte;
                end
            end
        end
    end
endmodule

// File: doc/result_packetizer.md
# result_packetizer

Output stage for the two-layer FC classifier, placed directly downstream of the final FC layer. It captures the 10-logit vector of signed int8 bytes and finds the winning class with a sequential argmax, one comparison per cycle. It then streams a 13-byte result frame to the UART transmitter: header, 10 logits, class index, XOR checksum. It replaces the controller's raw 10-byte dump with a framed, checksummed packet that the host can check.

## Interface
- `N_CLASSES`, 10, number of logits; byte i is `logits_flat[i*8 +: 8]`
- `HEADER`, 8'hA5, first byte of every frame
- `IDX_W`, 4, width of `class_idx` (must hold N_CLASSES-1)
- `clk` in 1: single clock, all logic on the rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: capture request; accepted only in IDLE
- `logits_flat` in N_CLASSES*8: signed two's-complement logits; sampled on the accepting cycle only
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse after the final frame byte handshakes
- `class_idx` out IDX_W: winning index; held until the next accepted `start`
- `class_valid` out 1: `class_idx` is valid
- `tx_data` out 8: frame byte
- `tx_valid` out 1: `tx_data` is offered
- `tx_ready` in 1: the sink takes the byte on a cycle where `tx_valid` and `tx_ready` are both high

## Operation
- States: IDLE → ARGMAX → SEND → DONE → IDLE.
- **IDLE:** when `start`=1, latch `logits_flat` into an internal register. Set best=logit0, best_idx=0, i=1. Clear `class_valid`. Go to ARGMAX.
- **ARGMAX:** each cycle, compare logit i with best as signed 8-bit values.
  - Update best and best_idx only when logit i is strictly greater, so ties keep the lowest index.
  - i increments each cycle.
  - After i=N_CLASSES-1 is compared: `class_idx`←best_idx, `class_valid`←1, byte counter←0, checksum←0, go to SEND.
- **SEND:** frame byte k, for k = 0..12:
  - k=0: HEADER.
  - k=1..10: logit k-1.
  - k=11: `class_idx` zero-extended to 8 bits.
  - k=12: checksum, the XOR of bytes 0..11.
  - The checksum accumulates on each handshake of bytes 0..11.
  - `tx_valid` stays high for the whole of SEND.
  - `tx_data` and `tx_valid` are stable while `tx_ready`=0. `tx_valid` never drops without a handshake.
  - After byte 12 handshakes, go to DONE.
- **DONE:** for one cycle, `done`=1 and `tx_valid`=0, then go to IDLE.
- `start` is ignored in ARGMAX, SEND and DONE. It has no queueing and no effect on the frame in flight.
- Reset values of all outputs: `busy`=0, `done`=0, `class_idx`=0, `class_valid`=0, `tx_data`=0, `tx_valid`=0. State resets to IDLE. Counters and checksum reset to 0.
- Reset mid-operation aborts immediately. No further bytes are offered and the partial frame is not resumed.
- If `rst` and `start` are high in the same cycle, reset wins.

## Timing
- Cycle 0: `start` accepted. `busy`=1 from cycle 1.
- ARGMAX occupies cycles 1..9 (N_CLASSES-1 comparisons). `class_valid`=1 from cycle 10.
- Header is offered (`tx_valid`=1) in cycle 10.
- With `tx_ready` held at 1, one byte handshakes per cycle. The checksum byte handshakes in cycle 22.
- `done`=1 in cycle 23. `busy`=0 and IDLE in cycle 24; a `start` in cycle 24 is accepted.
- Backpressure adds exactly one cycle per cycle of `tx_ready`=0 while `tx_valid`=1.
- Latency is independent of the logit values.

## Test plan
- Logits byte i = i (00..09), `tx_ready`=1 → class 9. Frame: A5 00 01 02 03 04 05 06 07 08 09 09 AD. Header in cycle 10, `done` in cycle 23.
- All logits F0 (-16) except logit5=10 (+16) → class 5, which proves the compare is signed (an unsigned compare gives 0). Checksum is the XOR of bytes 0..11.
- Logit2 = logit7 = 40, all others 00 → class 2 (tie goes to the lowest index).
- `tx_ready` low for 5 cycles after the 3rd byte, then toggling every cycle → `tx_data` stable while stalled, exactly 13 handshakes with correct bytes, `done` only after the checksum byte.
- `rst` pulsed after 4 handshakes → next cycle: `tx_valid`=0, `busy`=0, `class_valid`=0. A new `start` then yields a complete, correct 13-byte frame.
- `start` re-pulsed at cycles 5 and 15 with different logits → ignored; the frame matches the cycle-0 logits. A `start` in cycle 23 (DONE) is ignored; a `start` in cycle 24 is accepted.
